// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register for the 5-stage RV32I core.
// Load alignment and extension, misalignment detection and the writeback
// source mux all sit on the M side of the flops, so ResultW comes straight
// from a register. RdW/ResultW/RegWriteW feed the register file, which
// writes on the following negedge.
// Optional feature macro: WB_RETIRE_CNT_EN. When it is defined, the
// retired-instruction counter is built. When it is undefined, InstRetW is
// tied to 0 and no counter flops exist.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ValidM,
  input  logic              RegWriteM,
  input  logic [4:0]        RdM,
  input  logic [1:0]        ResultSrcM,
  input  logic [2:0]        Funct3M,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] ReadDataM,
  input  logic [DATA_W-1:0] PCPlus4M,
  input  logic              StallW,
  input  logic              FlushW,
  output logic              ValidW,
  output logic              RegWriteW,
  output logic [4:0]        RdW,
  output logic [DATA_W-1:0] ResultW,
  output logic              MisalignW,
  output logic [CNT_W-1:0]  InstRetW
);

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic [1:0]        off_s;
  logic [7:0]        byte_s;
  logic [15:0]       half_s;
  logic [DATA_W-1:0] load_val_s;
  logic              align_err_s;
  logic              misalign_s;
  logic [DATA_W-1:0] result_s;
  logic              wen_s;

  logic              valid_r;
  logic              regwrite_r;
  logic [4:0]        rd_r;
  logic [DATA_W-1:0] result_r;
  logic              misalign_r;

  // Select the addressed byte and half of the raw memory word.
  always_comb begin
    off_s  = ALUResultM[1:0];
    byte_s = ReadDataM[7:0];
    half_s = ReadDataM[15:0];
    case (off_s)
      2'd0:    byte_s = ReadDataM[7:0];
      2'd1:    byte_s = ReadDataM[15:8];
      2'd2:    byte_s = ReadDataM[23:16];
      2'd3:    byte_s = ReadDataM[31:24];
      default: byte_s = ReadDataM[7:0];
    endcase
    if (off_s[1]) begin
      half_s = ReadDataM[31:16];
    end else begin
      half_s = ReadDataM[15:0];
    end
  end

  // Extend the selected load data and flag alignment violations.
  // Unlisted Funct3 encodings behave as LW.
  always_comb begin
    load_val_s  = ReadDataM;
    align_err_s = 1'b0;
    case (Funct3M)
      F3_LB: begin
        load_val_s  = {{(DATA_W-8){byte_s[7]}}, byte_s};
        align_err_s = 1'b0;
      end
      F3_LBU: begin
        load_val_s  = {{(DATA_W-8){1'b0}}, byte_s};
        align_err_s = 1'b0;
      end
      F3_LH: begin
        load_val_s  = {{(DATA_W-16){half_s[15]}}, half_s};
        align_err_s = off_s[0];
      end
      F3_LHU: begin
        load_val_s  = {{(DATA_W-16){1'b0}}, half_s};
        align_err_s = off_s[0];
      end
      default: begin
        load_val_s  = ReadDataM;
        align_err_s = (off_s != 2'b00);
      end
    endcase
  end

  // Writeback source mux. A misaligned load passes the raw word through,
  // and the reserved source encoding falls back to the ALU result.
  always_comb begin
    misalign_s = 1'b0;
    result_s   = ALUResultM;
    case (ResultSrcM)
      SRC_ALU: begin
        result_s = ALUResultM;
      end
      SRC_LOAD: begin
        misalign_s = ValidM & align_err_s;
        if (align_err_s) begin
          result_s = ReadDataM;
        end else begin
          result_s = load_val_s;
        end
      end
      SRC_PC4: begin
        result_s = PCPlus4M;
      end
      default: begin
        result_s = ALUResultM;
      end
    endcase
    wen_s = ValidM & RegWriteM & (RdM != 5'd0) & ~misalign_s;
  end

  // WB pipeline register: flush beats stall, and stall beats load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r    <= 1'b0;
      regwrite_r <= 1'b0;
      rd_r       <= 5'd0;
      result_r   <= '0;
      misalign_r <= 1'b0;
    end else if (FlushW) begin
      valid_r    <= 1'b0;
      regwrite_r <= 1'b0;
      rd_r       <= 5'd0;
      result_r   <= '0;
      misalign_r <= 1'b0;
    end else if (!StallW) begin
      valid_r    <= ValidM;
      regwrite_r <= wen_s;
      rd_r       <= RdM;
      result_r   <= result_s;
      misalign_r <= misalign_s;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] instret_r;

  // Count every live instruction entering WB, including misaligned loads.
  // The counter wraps silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_r <= '0;
    end else if (!FlushW && !StallW && ValidM) begin
      instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign InstRetW = instret_r;
`else
  assign InstRetW = '0;
`endif

  assign ValidW    = valid_r;
  assign RegWriteW = regwrite_r;
  assign RdW       = rd_r;
  assign ResultW   = result_r;
  assign MisalignW = misalign_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed self-checking bench for mem_wb_stage.
// It models a register file that writes on negedge from the WB outputs.
// The counter is built with CNT_W=4 so that a wrap is easy to reach.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ValidM, RegWriteM, StallW, FlushW;
  logic [4:0]  RdM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, ReadDataM, PCPlus4M;
  logic        ValidW, RegWriteW, MisalignW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic [3:0]  InstRetW;

  logic [31:0] rf [0:31];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          exp_cnt  = 0;

  mem_wb_stage #(.DATA_W(32), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .ValidM(ValidM), .RegWriteM(RegWriteM), .RdM(RdM),
    .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .ALUResultM(ALUResultM),
    .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .StallW(StallW), .FlushW(FlushW),
    .ValidW(ValidW), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .MisalignW(MisalignW), .InstRetW(InstRetW)
  );

  always #5 clk = ~clk;

  // Register-file model: commits the WB write on the negedge.
  always @(negedge clk) begin
    if (RegWriteW && RdW != 5'd0) rf[RdW] <= ResultW;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] exp_ret();
`ifdef WB_RETIRE_CNT_EN
    return 32'(exp_cnt % 16);
`else
    return 32'd0;
`endif
  endfunction

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                       input logic [1:0] src, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [31:0] pc4);
    ValidM = v; RegWriteM = rw; RdM = rd; ResultSrcM = src; Funct3M = f3;
    ALUResultM = alu; ReadDataM = rdata; PCPlus4M = pc4;
  endtask

  // Advance one posedge and settle; this counts a normal valid capture.
  task automatic step();
    @(posedge clk);
    if (ValidM && !StallW && !FlushW) exp_cnt++;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rst = 1'b1; StallW = 1'b0; FlushW = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'd0, 32'd0, 32'd0);
    #12;
    check("rst_valid", {31'd0, ValidW}, 32'd0);
    check("rst_wen", {31'd0, RegWriteW}, 32'd0);
    check("rst_rd", {27'd0, RdW}, 32'd0);
    check("rst_result", ResultW, 32'd0);
    check("rst_mis", {31'd0, MisalignW}, 32'd0);
    check("rst_cnt", {28'd0, InstRetW}, 32'd0);
    rst = 1'b0;

    // ALU writeback to x5
    drive(1'b1, 1'b1, 5'd5, 2'b00, 3'b000, 32'h0000_1234, 32'd0, 32'd0);
    step();
    check("alu_rd", {27'd0, RdW}, 32'd5);
    check("alu_result", ResultW, 32'h0000_1234);
    check("alu_wen", {31'd0, RegWriteW}, 32'd1);
    check("alu_valid", {31'd0, ValidW}, 32'd1);
    @(negedge clk); #1;
    check("rf_x5", rf[5], 32'h0000_1234);

    // Reset asserted mid-cycle after a valid write to x6
    drive(1'b1, 1'b1, 5'd6, 2'b00, 3'b000, 32'h0000_0055, 32'd0, 32'd0);
    step();
    check("pre_rst_wen", {31'd0, RegWriteW}, 32'd1);
    #1 rst = 1'b1;
    #1;
    exp_cnt = 0;
    check("mid_rst_valid", {31'd0, ValidW}, 32'd0);
    check("mid_rst_wen", {31'd0, RegWriteW}, 32'd0);
    check("mid_rst_rd", {27'd0, RdW}, 32'd0);
    check("mid_rst_result", ResultW, 32'd0);
    check("mid_rst_cnt", {28'd0, InstRetW}, 32'd0);
    @(negedge clk); #1;
    check("rf_x6_untouched", rf[6], 32'd0);
    rst = 1'b0;

    // Load alignment and extension
    drive(1'b1, 1'b1, 5'd7, 2'b01, 3'b000, 32'h0000_0003, 32'h80FF_7F01, 32'd0);
    step();
    check("lb_off3", ResultW, 32'hFFFF_FF80);
    check("lb_wen", {31'd0, RegWriteW}, 32'd1);
    check("lb_mis", {31'd0, MisalignW}, 32'd0);
    drive(1'b1, 1'b1, 5'd7, 2'b01, 3'b100, 32'h0000_0001, 32'h80FF_7F01, 32'd0);
    step();
    check("lbu_off1", ResultW, 32'h0000_007F);
    drive(1'b1, 1'b1, 5'd7, 2'b01, 3'b001, 32'h0000_0002, 32'h80FF_7F01, 32'd0);
    step();
    check("lh_off2", ResultW, 32'hFFFF_80FF);
    drive(1'b1, 1'b1, 5'd7, 2'b01, 3'b101, 32'h0000_0000, 32'h80FF_7F01, 32'd0);
    step();
    check("lhu_off0", ResultW, 32'h0000_7F01);
    drive(1'b1, 1'b1, 5'd7, 2'b01, 3'b010, 32'h0000_0100, 32'h80FF_7F01, 32'd0);
    step();
    check("lw_off0", ResultW, 32'h80FF_7F01);

    // PC+4 and reserved source
    drive(1'b1, 1'b1, 5'd8, 2'b10, 3'b000, 32'h0000_0003, 32'h80FF_7F01, 32'h0000_0104);
    step();
    check("pc4", ResultW, 32'h0000_0104);
    drive(1'b1, 1'b1, 5'd8, 2'b11, 3'b001, 32'h0000_0003, 32'h80FF_7F01, 32'h0000_0104);
    step();
    check("src11_alu", ResultW, 32'h0000_0003);
    check("src11_mis", {31'd0, MisalignW}, 32'd0);

    // Misaligned loads
    drive(1'b1, 1'b1, 5'd9, 2'b01, 3'b010, 32'h0000_0102, 32'hDEAD_BEEF, 32'd0);
    step();
    check("lw_mis", {31'd0, MisalignW}, 32'd1);
    check("lw_mis_wen", {31'd0, RegWriteW}, 32'd0);
    check("lw_mis_valid", {31'd0, ValidW}, 32'd1);
    check("lw_mis_raw", ResultW, 32'hDEAD_BEEF);
    check("lw_mis_cnt", {28'd0, InstRetW}, exp_ret());
    drive(1'b1, 1'b1, 5'd9, 2'b01, 3'b101, 32'h0000_0003, 32'hDEAD_BEEF, 32'd0);
    step();
    check("lhu_mis", {31'd0, MisalignW}, 32'd1);

    // x0 is never written
    drive(1'b1, 1'b1, 5'd0, 2'b00, 3'b000, 32'h0000_7777, 32'd0, 32'd0);
    step();
    check("x0_wen", {31'd0, RegWriteW}, 32'd0);
    check("x0_valid", {31'd0, ValidW}, 32'd1);

    // Stall holds for two cycles
    drive(1'b1, 1'b1, 5'd9, 2'b00, 3'b000, 32'h0000_AAAA, 32'd0, 32'd0);
    step();
    drive(1'b1, 1'b1, 5'd10, 2'b00, 3'b000, 32'h0000_BBBB, 32'd0, 32'd0);
    StallW = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall_rd", {27'd0, RdW}, 32'd9);
      check("stall_result", ResultW, 32'h0000_AAAA);
      check("stall_wen", {31'd0, RegWriteW}, 32'd1);
      check("stall_cnt", {28'd0, InstRetW}, exp_ret());
    end

    // Stall together with flush: flush wins
    FlushW = 1'b1;
    step();
    check("flush_valid", {31'd0, ValidW}, 32'd0);
    check("flush_wen", {31'd0, RegWriteW}, 32'd0);
    check("flush_rd", {27'd0, RdW}, 32'd0);
    check("flush_result", ResultW, 32'd0);
    check("flush_cnt", {28'd0, InstRetW}, exp_ret());
    StallW = 1'b0; FlushW = 1'b0;

    // Bubble does not count
    drive(1'b0, 1'b1, 5'd11, 2'b00, 3'b000, 32'h0000_0011, 32'd0, 32'd0);
    step();
    check("bubble_valid", {31'd0, ValidW}, 32'd0);
    check("bubble_wen", {31'd0, RegWriteW}, 32'd0);
    check("bubble_cnt", {28'd0, InstRetW}, exp_ret());

    // Counter wrap: 17 valid instructions after reset
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    exp_cnt = 0;
    drive(1'b1, 1'b1, 5'd12, 2'b00, 3'b000, 32'h0000_0001, 32'd0, 32'd0);
    for (int i = 0; i < 17; i++) step();
`ifdef WB_RETIRE_CNT_EN
    check("wrap_cnt", {28'd0, InstRetW}, 32'd1);
`else
    check("nocnt_zero", {28'd0, InstRetW}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
